// File: rtl/sm_weight_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : sm_pkg                                                          |
// | Brief    : Shared widths, FSM states and int8 -> sign-magnitude helper.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sm_pkg;

  localparam int WEIGHT_W = 8;
  localparam int MAG_W    = 7;
  localparam int SHIFT_W  = 3;
  localparam logic [SHIFT_W-1:0] TOP_PLANE = 3'd6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_t;

  // The most negative code has no 7-bit magnitude, so it clamps to full scale.
  function automatic sm_t to_sm(input logic [WEIGHT_W-1:0] w);
    sm_t                 r;
    logic [WEIGHT_W-1:0] neg;
    neg    = ~w + 1'b1;
    r.sign = w[WEIGHT_W-1];
    if (!w[WEIGHT_W-1])
      r.mag = w[MAG_W-1:0];
    else if (w[MAG_W-1:0] == '0)
      r.mag = '1;
    else
      r.mag = neg[MAG_W-1:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_weight_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : sm_weight_serializer_if                                        |
// | Brief     : Weight-group input stream and bit-plane output stream.         |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface sm_weight_serializer_if
  import sm_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int WEIGHT_W = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*WEIGHT_W-1:0] in_weights;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES-1:0]          out_bits;
  logic [LANES-1:0]          out_signs;
  logic [SHIFT_W-1:0]        out_shift;
  logic                      out_last;

  modport master (
    output in_valid, in_weights, out_ready,
    input  in_ready, out_valid, out_bits, out_signs, out_shift, out_last
  );

  modport slave (
    input  in_valid, in_weights, out_ready,
    output in_ready, out_valid, out_bits, out_signs, out_shift, out_last
  );

endinterface
`default_nettype wire

// File: rtl/sm_weight_serializer_col_prienc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_col_prienc                                                   |
// | Brief    : Highest set column-mask bit strictly below a given shift.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sm_col_prienc
  import sm_pkg::*;
(
  input  logic [MAG_W-1:0]   i_mask,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [SHIFT_W-1:0] o_next,
  output logic               o_none
);

  // Ascending scan: the last qualifying bit wins, i.e. the highest one.
  always_comb begin
    o_next = '0;
    o_none = 1'b1;
    for (int b = 0; b < MAG_W; b++) begin
      if ((b < int'(i_shift)) && i_mask[b]) begin
        o_next = SHIFT_W'(b);
        o_none = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm_weight_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_weight_serializer                                            |
// | Brief    : Converts int8 weight groups to sign-magnitude and streams the   |
// |            magnitude bit-planes MSB-first. Define ZERO_COL_SKIP_EN to drop |
// |            planes whose column is zero in every lane.                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sm_weight_serializer
  import sm_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int WEIGHT_W = sm_pkg::WEIGHT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sm_weight_serializer_if.slave  bus,
  output logic                   busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LANES-1:0]   r_signs;
  logic [MAG_W-1:0]   r_mags [LANES];
  logic [SHIFT_W-1:0] r_shift;
  logic               r_last;
  logic [SHIFT_W-1:0] w_shift_nxt;
  logic               w_last_nxt;
  logic [LANES-1:0]   w_load_signs;
  logic [MAG_W-1:0]   w_load_mags [LANES];
  logic               w_accept;
  logic               w_beat;
  logic               w_ser;

  assign w_ser    = (r_state == SER);
  assign w_beat   = w_ser & bus.out_ready;
  assign w_accept = bus.in_valid & bus.in_ready;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_conv
    sm_t w_sm;
    assign w_sm             = to_sm(bus.in_weights[gi*WEIGHT_W +: WEIGHT_W]);
    assign w_load_signs[gi] = w_sm.sign;
    assign w_load_mags[gi]  = w_sm.mag;
  end

`ifdef ZERO_COL_SKIP_EN
  logic [MAG_W-1:0]   r_mask;
  logic [MAG_W-1:0]   w_load_mask;
  logic [MAG_W-1:0]   w_pe_mask;
  logic [SHIFT_W-1:0] w_pe_shift;
  logic [MAG_W-1:0]   w_below;
  logic               w_none;

  always_comb begin
    w_load_mask = '0;
    for (int i = 0; i < LANES; i++)
      w_load_mask = w_load_mask | w_load_mags[i];
  end

  // On load, a search below MAG_W finds the top populated plane of the new group.
  assign w_pe_mask  = w_accept ? w_load_mask : r_mask;
  assign w_pe_shift = w_accept ? SHIFT_W'(MAG_W) : r_shift;

  sm_col_prienc u_prienc (
    .i_mask  (w_pe_mask),
    .i_shift (w_pe_shift),
    .o_next  (w_shift_nxt),
    .o_none  (w_none)
  );

  assign w_below    = w_pe_mask & ~({MAG_W{1'b1}} << w_shift_nxt);
  assign w_last_nxt = w_none | (w_below == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mask <= '0;
    else if (w_accept)
      r_mask <= w_load_mask;
  end
`else
  assign w_shift_nxt = w_accept ? TOP_PLANE : (r_shift - 1'b1);
  assign w_last_nxt  = (w_shift_nxt == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SER;
      SER:     if (w_beat && r_last) w_state_nxt = w_accept ? SER : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = w_ser;
    bus.out_last  = w_ser & r_last;
    busy          = w_ser;
    bus.in_ready  = (r_state == IDLE) | (w_beat & r_last);
    for (int i = 0; i < LANES; i++)
      bus.out_bits[i] = w_ser & r_mags[i][r_shift];
  end

  assign bus.out_signs = r_signs;
  assign bus.out_shift = r_shift;

  // A coincident last beat and new group is resolved by the load taking priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signs <= '0;
      r_shift <= '0;
      r_last  <= 1'b0;
      for (int i = 0; i < LANES; i++)
        r_mags[i] <= '0;
    end else if (w_accept) begin
      r_signs <= w_load_signs;
      r_mags  <= w_load_mags;
      r_shift <= w_shift_nxt;
      r_last  <= w_last_nxt;
    end else if (w_beat && !r_last) begin
      r_shift <= w_shift_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_weight_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sm_weight_serializer                                         |
// | Brief    : Scoreboard bench for sm_weight_serializer.                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sm_weight_serializer;

  localparam int LANES    = 8;
  localparam int WEIGHT_W = 8;
`ifdef ZERO_COL_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [LANES-1:0] bits;
    logic [LANES-1:0] signs;
    logic [2:0]       shift;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  sm_weight_serializer_if #(.LANES(LANES), .WEIGHT_W(WEIGHT_W)) bus ();

  sm_weight_serializer #(.LANES(LANES), .WEIGHT_W(WEIGHT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic magnitudes, then one beat per emitted plane.
  task automatic push_expected(input logic [LANES*WEIGHT_W-1:0] wv);
    int               mag [LANES];
    logic [LANES-1:0] sg;
    int               planes[$];
    beat_t            b;
    for (int i = 0; i < LANES; i++) begin
      int v;
      v      = int'($signed(wv[i*WEIGHT_W +: WEIGHT_W]));
      sg[i]  = (v < 0);
      mag[i] = (v < 0) ? -v : v;
      if (mag[i] > 127) mag[i] = 127;
    end
    for (int p = 6; p >= 0; p--) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < LANES; i++)
        if (((mag[i] >> p) & 1) == 1) any = 1'b1;
      if (!SKIP || any) planes.push_back(p);
    end
    if (planes.size() == 0) planes.push_back(0);
    for (int k = 0; k < planes.size(); k++) begin
      for (int i = 0; i < LANES; i++)
        b.bits[i] = ((mag[i] >> planes[k]) & 1) == 1;
      b.signs = sg;
      b.shift = 3'(planes[k]);
      b.last  = (k == planes.size() - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_group(input logic [LANES*WEIGHT_W-1:0] wv);
    bit ok;
    ok             = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_weights = wv;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) push_expected(wv);
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 1000 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_weights = {$urandom, $urandom};
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*WEIGHT_W-1:0] fill(input logic [7:0] w);
    logic [LANES*WEIGHT_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WEIGHT_W +: WEIGHT_W] = w;
    return v;
  endfunction

  function automatic logic [LANES*WEIGHT_W-1:0] rand_group();
    logic [LANES*WEIGHT_W-1:0] v;
    logic [7:0]                m;
    case ($urandom_range(0, 3))
      0:       m = 8'hFF;
      1:       m = 8'h0F;
      2:       m = 8'h83;
      default: m = 8'h30;
    endcase
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 9))
        0:       v[i*WEIGHT_W +: WEIGHT_W] = 8'h80;
        1:       v[i*WEIGHT_W +: WEIGHT_W] = 8'h00;
        default: v[i*WEIGHT_W +: WEIGHT_W] = 8'($urandom) & m;
      endcase
    end
    return v;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops one expected beat per output handshake.
  initial begin
    logic [31:0] prev_vec;
    bit          prev_stall;
    bit          expect_next;
    beat_t       e;
    prev_vec    = '0;
    prev_stall  = 1'b0;
    expect_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall  = 1'b0;
        expect_next = 1'b0;
        continue;
      end
      if (expect_next) chk("no_bubble_valid", bus.out_valid, 1);
      expect_next = 1'b0;
      if (prev_stall)
        chk("stall_hold", {11'b0, bus.out_bits, bus.out_signs, bus.out_shift, bus.out_last, bus.out_valid}, prev_vec);
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_vec   = {11'b0, bus.out_bits, bus.out_signs, bus.out_shift, bus.out_last, bus.out_valid};
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got shift %0d, expected no beat", bus.out_shift);
        end else begin
          e = exp_q.pop_front();
          chk("out_bits",  bus.out_bits,  e.bits);
          chk("out_signs", bus.out_signs, e.signs);
          chk("out_shift", bus.out_shift, e.shift);
          chk("out_last",  bus.out_last,  e.last);
        end
        if (bus.out_last && bus.in_valid && bus.in_ready) expect_next = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*WEIGHT_W-1:0] g;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_weights = '0;
    bus.out_ready  = 1'b1;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_bits",  bus.out_bits,  0);
    chk("rst_out_signs", bus.out_signs, 0);
    chk("rst_out_shift", bus.out_shift, 0);
    chk("rst_out_last",  bus.out_last,  0);
    chk("rst_busy",      busy,          0);
    chk("rst_in_ready",  bus.in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lanes {5, -3, 0, ...}, then saturating and all-zero groups.
    g = '0;
    g[7:0]  = 8'd5;
    g[15:8] = 8'hFD;
    send_group(g);
    drain();
    send_group(fill(8'h80));
    drain();
    send_group(fill(8'h00));
    drain();

    // Random stalls with back-to-back offered groups.
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) send_group(rand_group());
    drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;

    // Asynchronous reset during the third beat.
    send_group(fill(8'd127));
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_shift", bus.out_shift, 4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",    bus.out_valid, 0);
    chk("async_rst_busy",     busy,          0);
    chk("async_rst_last",     bus.out_last,  0);
    chk("async_rst_in_ready", bus.in_ready,  1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready,  1);
    chk("post_rst_valid",    bus.out_valid, 0);
    @(posedge clk);
    #1;
    g = '0;
    g[23:16] = 8'hF4;
    g[63:56] = 8'd9;
    send_group(g);
    send_group(rand_group());
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
